// File: rtl/msi_pkg.sv
// Shared encodings for the MSI cache array: bus message codes, cache line
// states and the bus controller's FSM states.
package msi_pkg;

  localparam int BUS_MSG_W = 3;

  localparam logic [BUS_MSG_W-1:0] BUS_IDLE = 3'd0;
  localparam logic [BUS_MSG_W-1:0] BUS_RD   = 3'd1;
  localparam logic [BUS_MSG_W-1:0] BUS_RDX  = 3'd2;
  localparam logic [BUS_MSG_W-1:0] BUS_UPGR = 3'd3;

  localparam logic [1:0] CS_INVALID  = 2'd0;
  localparam logic [1:0] CS_SHARED   = 2'd1;
  localparam logic [1:0] CS_MODIFIED = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SNOOP = 2'd2,
    ST_FLUSH = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning circularly
// upward from ptr_i. The pointer itself lives in the caller.
module rr_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_CPUS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [NUM_CPUS-1:0] grant_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                vld_o
);

  logic [IDX_W:0] w_pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    vld_o   = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      // Wrap ptr+i back into [0, NUM_CPUS) without relying on power-of-two sizes.
      w_pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NUM_CPUS)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_CPUS);
      end
      if (!vld_o && req_i[w_pos[IDX_W-1:0]]) begin
        vld_o                        = 1'b1;
        idx_o                        = w_pos[IDX_W-1:0];
        grant_o[w_pos[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_bus_ctrl.sv
// Snooping-bus controller: round-robin grant, latch the owner's message,
// broadcast it to the other caches, then sequence an optional flush phase.
module msi_bus_ctrl
  import msi_pkg::*;
#(
  parameter  int NUM_CPUS     = 4,
  parameter  int ADDR_WIDTH   = 2,
  parameter  int FLUSH_CYCLES = 2,
  localparam int IDX_W        = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CPUS-1:0]            req_i,
  output logic [NUM_CPUS-1:0]            grant_o,
  input  logic [BUS_MSG_W*NUM_CPUS-1:0]  msg_i,
  input  logic [ADDR_WIDTH*NUM_CPUS-1:0] addr_i,
  input  logic [NUM_CPUS-1:0]            flush_i,
  output logic [BUS_MSG_W*NUM_CPUS-1:0]  snoop_msg_o,
  output logic [ADDR_WIDTH-1:0]          snoop_addr_o,
  output logic [IDX_W-1:0]               owner_o,
  output logic                           busy_o,
  output logic [NUM_CPUS-1:0]            flush_src_o,
  output logic                           error_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  ctrl_state_t             r_state;
  ctrl_state_t             w_state_nxt;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_owner;
  logic [NUM_CPUS-1:0]     r_owner_oh;
  logic [BUS_MSG_W-1:0]    r_msg;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [NUM_CPUS-1:0]     r_flush_src;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_error;

  logic [NUM_CPUS-1:0]     w_arb_grant;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_vld;
  logic [BUS_MSG_W-1:0]    w_own_msg;
  logic [ADDR_WIDTH-1:0]   w_own_addr;
  logic                    w_msg_illegal;
  logic [NUM_CPUS-1:0]     w_flush_cand;
  logic [NUM_CPUS-1:0]     w_flush_lo;
  logic                    w_flush_multi;

  rr_arbiter #(
    .NUM_CPUS (NUM_CPUS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_arb_grant),
    .idx_o   (w_arb_idx),
    .vld_o   (w_arb_vld)
  );

  assign w_own_msg     = msg_i[r_owner*BUS_MSG_W +: BUS_MSG_W];
  assign w_own_addr    = addr_i[r_owner*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_msg_illegal = (w_own_msg > BUS_UPGR);

  // The owner's own flush line is meaningless during its snoop; mask it out.
  assign w_flush_cand  = flush_i & ~r_owner_oh;
  assign w_flush_lo    = w_flush_cand & (~w_flush_cand + NUM_CPUS'(1));
  assign w_flush_multi = |(w_flush_cand & (w_flush_cand - NUM_CPUS'(1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_vld) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if ((w_own_msg == BUS_IDLE) || w_msg_illegal) w_state_nxt = ST_IDLE;
        else                                          w_state_nxt = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (|w_flush_cand) w_state_nxt = ST_FLUSH;
        else               w_state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_o     = (r_state == ST_GRANT) ? r_owner_oh : '0;
    busy_o      = (r_state != ST_IDLE);
    snoop_msg_o = '0;
    for (int k = 0; k < NUM_CPUS; k++) begin
      snoop_msg_o[k*BUS_MSG_W +: BUS_MSG_W] =
        ((r_state == ST_SNOOP) && !r_owner_oh[k]) ? r_msg : BUS_IDLE;
    end
  end

  assign snoop_addr_o = r_addr;
  assign owner_o      = r_owner;
  assign flush_src_o  = r_flush_src;
  assign error_o      = r_error;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_owner_oh  <= '0;
      r_msg       <= BUS_IDLE;
      r_addr      <= '0;
      r_flush_src <= '0;
      r_cnt       <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_owner    <= w_arb_idx;
            r_owner_oh <= w_arb_grant;
            r_rr_ptr   <= (w_arb_idx == IDX_W'(NUM_CPUS-1)) ? '0 : w_arb_idx + 1'b1;
          end
        end
        ST_GRANT: begin
          r_msg  <= w_msg_illegal ? BUS_IDLE : w_own_msg;
          r_addr <= w_own_addr;
          if (w_msg_illegal) r_error <= 1'b1;
        end
        ST_SNOOP: begin
          if (|w_flush_cand) begin
            r_flush_src <= w_flush_lo;
            r_cnt       <= CNT_W'(FLUSH_CYCLES-1);
            if (w_flush_multi) r_error <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == '0) r_flush_src <= '0;
          else             r_cnt       <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Directed bench for msi_bus_ctrl: a per-cycle vector table plus hand-written
// fairness, double-flush and mid-flush reset sequences.
module tb_msi_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [3:0]  grant_o;
  logic [11:0] msg_i;
  logic [7:0]  addr_i;
  logic [3:0]  flush_i;
  logic [11:0] snoop_msg_o;
  logic [1:0]  snoop_addr_o;
  logic [1:0]  owner_o;
  logic        busy_o;
  logic [3:0]  flush_src_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  msi_bus_ctrl #(.NUM_CPUS(4), .ADDR_WIDTH(2), .FLUSH_CYCLES(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .grant_o      (grant_o),
    .msg_i        (msg_i),
    .addr_i       (addr_i),
    .flush_i      (flush_i),
    .snoop_msg_o  (snoop_msg_o),
    .snoop_addr_o (snoop_addr_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o),
    .flush_src_o  (flush_src_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] msg;
    logic [7:0]  addr;
    logic [3:0]  flush;
    logic [3:0]  e_gnt;
    logic [11:0] e_snp;
    logic [1:0]  e_addr;
    logic        chk_a;
    logic        e_busy;
    logic [3:0]  e_fs;
    logic        e_err;
    logic [1:0]  e_own;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [11:0] all_rd;
    logic [11:0] exp_snp;
    logic [1:0]  exp_own;

    //                req      msg      addr   flush    gnt      snp      a     ca    busy  fs       err   own
    tbl[0]  = '{4'b0010, 12'h008, 8'h08, 4'b0000, 4'b0010, 12'h000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[1]  = '{4'b0000, 12'h008, 8'h08, 4'b0000, 4'b0000, 12'h241, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1};
    tbl[2]  = '{4'b0000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    tbl[3]  = '{4'b0001, 12'h002, 8'h01, 4'b0000, 4'b0001, 12'h000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[4]  = '{4'b0000, 12'h002, 8'h01, 4'b0000, 4'b0000, 12'h490, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[5]  = '{4'b1000, 12'h000, 8'h00, 4'b0100, 4'b0000, 12'h000, 2'd1, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0};
    tbl[6]  = '{4'b1000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd1, 1'b1, 1'b1, 4'b0100, 1'b0, 2'd0};
    tbl[7]  = '{4'b1000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[8]  = '{4'b1000, 12'h200, 8'hC0, 4'b0000, 4'b1000, 12'h000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[9]  = '{4'b0000, 12'h200, 8'hC0, 4'b0000, 4'b0000, 12'h049, 2'd3, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[10] = '{4'b0000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3};
    tbl[11] = '{4'b0100, 12'h000, 8'h00, 4'b0000, 4'b0100, 12'h000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[12] = '{4'b0000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
    tbl[13] = '{4'b0001, 12'h005, 8'h00, 4'b0000, 4'b0001, 12'h000, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{4'b0000, 12'h005, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 12'h000, 8'h00, 4'b0000, 4'b0000, 12'h000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};

    rst_i   = 1'b0;
    req_i   = '0;
    msg_i   = '0;
    addr_i  = '0;
    flush_i = '0;
    tick();
    tick();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_snoop", 32'(snoop_msg_o), 32'h0);
    chk("rst_addr", 32'(snoop_addr_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_fsrc", 32'(flush_src_o), 32'h0);
    chk("rst_err", 32'(error_o), 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 16; i++) begin
      req_i   = tbl[i].req;
      msg_i   = tbl[i].msg;
      addr_i  = tbl[i].addr;
      flush_i = tbl[i].flush;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_snoop", i), 32'(snoop_msg_o), 32'(tbl[i].e_snp));
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_fsrc", i), 32'(flush_src_o), 32'(tbl[i].e_fs));
      chk($sformatf("v%0d_err", i), 32'(error_o), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_owner", i), 32'(owner_o), 32'(tbl[i].e_own));
      if (tbl[i].chk_a) chk($sformatf("v%0d_addr", i), 32'(snoop_addr_o), 32'(tbl[i].e_addr));
    end

    // Fairness from a fresh reset: all four request continuously.
    rst_i   = 1'b0;
    req_i   = '0;
    msg_i   = '0;
    flush_i = '0;
    tick();
    chk("fair_rst_err", 32'(error_o), 32'h0);
    rst_i  = 1'b1;
    all_rd = 12'h249;
    req_i  = 4'b1111;
    msg_i  = all_rd;
    addr_i = 8'h00;
    for (int t = 0; t < 8; t++) begin
      exp_own = 2'(t % 4);
      tick();
      chk($sformatf("fair%0d_grant", t), 32'(grant_o), 32'(4'b0001 << exp_own));
      chk($sformatf("fair%0d_owner", t), 32'(owner_o), 32'(exp_own));
      tick();
      exp_snp = all_rd & ~(12'h7 << (3 * exp_own));
      chk($sformatf("fair%0d_snoop", t), 32'(snoop_msg_o), 32'(exp_snp));
      chk($sformatf("fair%0d_gnt_low", t), 32'(grant_o), 32'h0);
      tick();
      chk($sformatf("fair%0d_idle", t), 32'(busy_o), 32'h0);
    end

    // Double flush: caches 1 and 3 both respond; owner 0's own flush bit is ignored.
    req_i  = 4'b0001;
    msg_i  = 12'h001;
    addr_i = 8'h02;
    tick();
    chk("dbl_grant", 32'(grant_o), 32'h1);
    req_i = 4'b0000;
    tick();
    chk("dbl_snoop", 32'(snoop_msg_o), 32'h248);
    chk("dbl_addr", 32'(snoop_addr_o), 32'h2);
    flush_i = 4'b1011;
    tick();
    flush_i = 4'b0000;
    chk("dbl_fsrc", 32'(flush_src_o), 32'h2);
    chk("dbl_err", 32'(error_o), 32'h1);
    chk("dbl_busy", 32'(busy_o), 32'h1);
    chk("dbl_snoop_idle", 32'(snoop_msg_o), 32'h0);

    // Reset during FLUSH, then all request: rr_ptr must be back at 0.
    rst_i = 1'b0;
    req_i = 4'b1111;
    tick();
    chk("midrst_grant", 32'(grant_o), 32'h0);
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_fsrc", 32'(flush_src_o), 32'h0);
    chk("midrst_err", 32'(error_o), 32'h0);
    rst_i = 1'b1;
    tick();
    chk("postrst_grant", 32'(grant_o), 32'h1);
    chk("postrst_owner", 32'(owner_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msi_bus_ctrl.md
Name: msi_bus_ctrl

Overview:
- Snooping-bus controller for the MSI cache array.
- Arbitrates bus requests from NUM_CPUS caches round-robin and grants the bus to one cache.
- Captures the winner's bus message and address, then broadcasts them as a snoop to every other cache.
- Sequences the flush phase when a Modified holder responds.

Parameters:
- NUM_CPUS, 4, number of caches on the bus (≥2).
- ADDR_WIDTH, 2, cache line address width; matches the cache's NUM_LINES-wide address.
- FLUSH_CYCLES, 2, cycles the bus stays occupied by a flush (≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low.
- req_i  in  NUM_CPUS  per-cache bus request (cache pr_bus_req_o).
- grant_o  out  NUM_CPUS  one-hot grant (cache pr_bus_req_i).
- msg_i  in  3*NUM_CPUS  per-cache bus message; slot k = bits [3k+2:3k].
- addr_i  in  ADDR_WIDTH*NUM_CPUS  per-cache bus address, sliced the same way as msg_i.
- flush_i  in  NUM_CPUS  per-cache flush indication (cache flush_o).
- snoop_msg_o  out  3*NUM_CPUS  per-cache snoop message (cache bus_msg_i).
- snoop_addr_o  out  ADDR_WIDTH  broadcast snoop address (cache addr_i).
- owner_o  out  clog2(NUM_CPUS)  index of the current bus owner.
- busy_o  out  1  high in any state other than IDLE.
- flush_src_o  out  NUM_CPUS  registered one-hot flushing cache; valid in FLUSH.
- error_o  out  1  sticky protocol error.

Behaviour:
- Bus message codes: IDLE=0, RD=1, RDX=2, UPGR=3. Codes 4–7 are illegal.
- Reset (rst_i==0 at posedge):
  - state=IDLE, rr_ptr=0, flush counter=0.
  - All outputs 0; every snoop_msg_o slot = BUS_IDLE.
  - Reset mid-operation abandons the transaction with no broadcast.
- FSM states: IDLE, GRANT, SNOOP, FLUSH.
- IDLE:
  - If req_i != 0, pick the first set bit scanning circularly from rr_ptr upward. Register it as owner and set grant_o to that one-hot bit. Next state GRANT.
  - rr_ptr ← (winner+1) mod NUM_CPUS.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - grant_o is high for exactly this one cycle.
  - The owner drives msg_i/addr_i combinationally; latch the owner's slot at the end of the cycle.
  - Latched msg == BUS_IDLE: the owner no longer needs the bus. Next state IDLE, no broadcast.
  - Latched msg > 3: set error_o, treat as IDLE, next state IDLE.
  - Otherwise next state SNOOP.
- SNOOP (1 cycle):
  - Every non-owner slot of snoop_msg_o = latched msg; the owner slot = BUS_IDLE.
  - snoop_addr_o = latched addr.
  - Sample flush_i & ~owner_onehot:
    - Zero bits → IDLE.
    - Exactly one bit → register it in flush_src_o, load counter = FLUSH_CYCLES-1, go to FLUSH.
    - Two or more bits → set error_o, register the lowest-index bit, go to FLUSH.
  - A flush_i bit from the owner is ignored.
- FLUSH:
  - snoop_msg_o all BUS_IDLE; snoop_addr_o held; flush_src_o held.
  - Counter decrements each cycle; at 0 go to IDLE and clear flush_src_o.
  - New requests wait.
- Fairness: with all requesters held high, grants rotate 0,1,2,…; a requester waits at most NUM_CPUS-1 transactions.
- Requests arriving or withdrawn outside IDLE are ignored until the next IDLE cycle; the arbiter has no request memory.
- Back-to-back: IDLE→GRANT→SNOOP→IDLE, so the minimum transaction is 3 cycles.
- error_o clears only on reset.
- owner_o holds its value from grant until the next grant; 0 after reset.

Decomposition:
- Shared package msi_pkg:
  - BUS_IDLE/RD/RDX/UPGR localparams and the 3-bit bus message width.
  - Cache state codes INVALID/SHARED/MODIFIED.
  - Controller state encodings IDLE/GRANT/SNOOP/FLUSH.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs req and rr_ptr; outputs one-hot grant, index and valid. Pointer register stays in msi_bus_ctrl.

Test Plan:
- Single request: req_i=0b0010, cache 1 drives RD on addr 2. grant_o=0b0010 one cycle after the request. Next cycle snoop_msg_o slots 0,2,3 = 1, slot 1 = 0, snoop_addr_o=2. Then IDLE.
- Fairness: req_i=0b1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3 with no gaps beyond 3 cycles per transaction.
- Flush: cache 0 issues RDX addr 1; cache 2 raises flush_i in SNOOP, FLUSH_CYCLES=2. flush_src_o=0b0100 for 2 cycles, busy_o stays high, cache 3 request granted only afterwards.
- Abort and illegal message: owner drives BUS_IDLE in GRANT → no snoop cycle, error_o=0. Owner drives 5 → error_o=1 and sticky.
- Double flush: caches 1 and 3 both raise flush_i → error_o=1, flush_src_o=0b0010.
- Reset mid-FLUSH: rst_i=0 for one edge → grant_o=0, busy_o=0, flush_src_o=0, error_o=0. The next request from cache 0 is granted first (rr_ptr=0).
